// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch FSM state encoding and
// instruction field positions used to split the IF/ID word for control_unit.
package cpu_pkg;

    localparam int PC_W    = 9;
    localparam int INSTR_W = 16;

    // Instruction field bit positions
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 13;
    localparam int OP_MSB     = 12;
    localparam int OP_LSB     = 11;
    localparam int COND_MSB   = 10;
    localparam int COND_LSB   = 8;

    // Fetch FSM state encoding
    typedef enum logic [2:0] {
        FS_IDLE   = 3'd0,
        FS_REQ    = 3'd1,
        FS_WAIT   = 3'd2,
        FS_HOLD   = 3'd3,
        FS_DROP   = 3'd4,
        FS_HALTED = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch_stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;
    import cpu_pkg::*;

    logic               req;
    logic [PC_W-1:0]    addr;
    logic               gnt;
    logic               rvalid;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register plus a one-entry holding buffer that parks a
// fetched word arriving while the downstream stage is stalled.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,     // drop IF/ID contents and buffer
    input  logic               load_mem,  // take rdata straight into IF/ID
    input  logic               cap_buf,   // park rdata in the buffer
    input  logic               load_buf,  // move the buffer into IF/ID
    input  logic [INSTR_W-1:0] rdata,
    input  logic [PC_W-1:0]    pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc
);

    logic               buf_valid;
    logic [INSTR_W-1:0] buf_data;

    // IF/ID and buffer update; with no load pulse everything holds.
    // The parked word belongs to the current pc, so only data is buffered.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid  <= 1'b0;
            id_instr  <= '0;
            id_pc     <= '0;
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (flush) begin
            id_valid  <= 1'b0;
            buf_valid <= 1'b0;
        end else begin
            if (load_mem) begin
                id_valid <= 1'b1;
                id_instr <= rdata;
                id_pc    <= pc;
            end
            if (cap_buf) begin
                buf_valid <= 1'b1;
                buf_data  <= rdata;
            end
            if (load_buf && buf_valid) begin
                id_valid  <= 1'b1;
                id_instr  <= buf_data;
                id_pc     <= pc;
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one-outstanding-request fetch FSM and PC,
// feeding the IF/ID register. Optional performance counters are built
// when IF_PERF_CNT_EN is defined.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    fetch_stage_if.master      imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               halted,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [2:0]         id_opcode,
    output logic [1:0]         id_op,
    output logic [2:0]         id_cond
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]        perf_fetch,
    output logic [15:0]        perf_stall
`endif
);

    localparam logic [2:0] S_IDLE   = FS_IDLE;
    localparam logic [2:0] S_REQ    = FS_REQ;
    localparam logic [2:0] S_WAIT   = FS_WAIT;
    localparam logic [2:0] S_HOLD   = FS_HOLD;
    localparam logic [2:0] S_DROP   = FS_DROP;
    localparam logic [2:0] S_HALTED = FS_HALTED;

    logic [2:0]      state, state_d;
    logic [PC_W-1:0] pc, pc_d;
    logic            flush, load_mem, cap_buf, load_buf;
    logic            outstanding;

    // A granted request whose data has not yet returned, including a grant
    // landing this very cycle; its data must be dropped after a redirect.
    assign outstanding = (state == S_REQ && imem.gnt) ||
                         ((state == S_WAIT || state == S_DROP) && !imem.rvalid);

    // Next-state / pc / IF/ID control: halt beats redirect beats normal flow
    always_comb begin
        state_d  = state;
        pc_d     = pc;
        flush    = 1'b0;
        load_mem = 1'b0;
        cap_buf  = 1'b0;
        load_buf = 1'b0;
        if (state != S_HALTED) begin
            if (halt) begin
                state_d = S_HALTED;
            end else if (redirect) begin
                flush   = 1'b1;
                pc_d    = redirect_pc;
                state_d = outstanding ? S_DROP : S_REQ;
            end else begin
                case (state)
                    S_IDLE: state_d = S_REQ;
                    S_REQ:  if (imem.gnt) state_d = S_WAIT;
                    S_WAIT: begin
                        if (imem.rvalid) begin
                            if (stall) begin
                                cap_buf = 1'b1;
                                state_d = S_HOLD;
                            end else begin
                                load_mem = 1'b1;
                                pc_d     = pc + 1'b1;
                                state_d  = S_REQ;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            load_buf = 1'b1;
                            pc_d     = pc + 1'b1;
                            state_d  = S_REQ;
                        end
                    end
                    S_DROP: if (imem.rvalid) state_d = S_REQ;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // State and pc registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
        end
    end

    assign imem.req  = (state == S_REQ);
    assign imem.addr = pc;
    assign halted    = (state == S_HALTED);

    if_id_reg u_if_id (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .load_mem (load_mem),
        .cap_buf  (cap_buf),
        .load_buf (load_buf),
        .rdata    (imem.rdata),
        .pc       (pc),
        .id_valid (id_valid),
        .id_instr (id_instr),
        .id_pc    (id_pc)
    );

    assign id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
    assign id_op     = id_instr[OP_MSB:OP_LSB];
    assign id_cond   = id_instr[COND_MSB:COND_LSB];

`ifdef IF_PERF_CNT_EN
    logic [15:0] perf_fetch_q, perf_stall_q;

    // Saturating event counters, frozen while halted
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else if (state != S_HALTED) begin
            if ((load_mem || load_buf) && perf_fetch_q != 16'hFFFF)
                perf_fetch_q <= perf_fetch_q + 16'd1;
            if (stall && id_valid && perf_stall_q != 16'hFFFF)
                perf_stall_q <= perf_stall_q + 16'd1;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have clock and reset: clk input 1, rising-edge clock; reset input 1, synchronous, active-high.
REQ-002 SHALL have imem_req output 1, instruction-fetch request; imem_addr output 9, fetch address (PC).
REQ-003 SHALL have imem_gnt input 1, request accepted this cycle; imem_rvalid input 1, read data valid; imem_rdata input 16, instruction word.
REQ-004 SHALL have stall input 1, hold IF/ID register (downstream hazard); redirect input 1, branch/call/return taken; redirect_pc input 9, target address.
REQ-005 SHALL have halt input 1, decoded HALT from control_unit; halted output 1, stage frozen.
REQ-006 SHALL have id_valid output 1; id_instr output 16; id_pc output 9, address of id_instr.
REQ-007 SHALL have id_opcode output 3 = id_instr[15:13]; id_op output 2 = id_instr[12:11]; id_cond output 3 = id_instr[10:8], combinational from the IF/ID register, feeding control_unit {opcode, op, cond}.

Function
REQ-008 SHALL implement states IDLE, REQ, WAIT, HOLD, DROP, HALTED.
REQ-009 IDLE: SHALL go to REQ on the cycle after reset deasserts.
REQ-010 REQ: SHALL drive imem_req=1, imem_addr=pc; on imem_gnt SHALL go to WAIT.
REQ-011 WAIT: SHALL keep imem_req=0; response arrives at least 1 cycle after grant; only one request outstanding.
REQ-012 WAIT & imem_rvalid & !stall: SHALL load id_instr=imem_rdata, id_pc=pc, id_valid=1; pc<=pc+1, wrapping 9'h1FF->9'h000; next state REQ.
REQ-013 WAIT & imem_rvalid & stall: SHALL capture imem_rdata in a one-entry holding buffer; next state HOLD; IF/ID unchanged.
REQ-014 HOLD: SHALL move the buffer into IF/ID on the first cycle with stall=0, then increment pc and go to REQ.
REQ-015 stall=1 with no load: IF/ID SHALL hold all values, including id_valid.
REQ-016 redirect=1 (priority over stall and rvalid): SHALL set id_valid=0, invalidate the buffer, and load pc<=redirect_pc.
REQ-016a After a redirect, the next state SHALL be DROP if a request is outstanding (granted, no rvalid yet), else REQ.
REQ-017 DROP: SHALL discard the next imem_rvalid data without touching IF/ID; next state REQ.
REQ-018 redirect and imem_rvalid in the same WAIT cycle: the data SHALL be discarded; next state REQ.
REQ-019 halt=1 in any non-HALTED state (priority over redirect): SHALL go to HALTED.
REQ-019a HALTED SHALL assert halted=1, imem_req=0, and freeze pc and IF/ID; any outstanding rvalid is ignored; only reset exits HALTED.
REQ-020 imem_req SHALL be 0 in every state other than REQ.

Reset
REQ-021 On reset=1 at a clock edge: state=IDLE, pc=9'h000, id_valid=0, id_instr=16'h0000, id_pc=9'h000, buffer invalid, halted=0, imem_req=0.
REQ-022 Reset mid-transaction SHALL abandon any outstanding request; a late imem_rvalid in IDLE SHALL be ignored.

Configuration
REQ-023 With IF_PERF_CNT_EN defined: SHALL add outputs perf_fetch 16 (IF/ID loads) and perf_stall 16 (cycles with stall=1 & id_valid=1); both saturate at 16'hFFFF, freeze in HALTED, and clear on reset.
REQ-024 Without IF_PERF_CNT_EN: these ports and their counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 Shared package cpu_pkg SHALL hold PC_W=9, INSTR_W=16, the fetch state enum, and the opcode/op field bit positions.
REQ-026 The IF/ID register with its holding buffer SHALL be sub-module if_id_reg; the FSM and pc SHALL stay in fetch_stage.

Verification
REQ-027 Reset, then gnt at cycle 1, rvalid at cycle 2 with rdata=16'hD105 -> id_valid=1, id_instr=16'hD105, id_pc=0, id_opcode=3'b110, id_op=2'b10, pc=1.
REQ-028 stall=1 across rvalid (rdata=16'hA1C0) for 3 cycles -> IF/ID unchanged for 3 cycles; on the 4th cycle id_instr=16'hA1C0 and pc increments exactly once.
REQ-029 redirect=1, redirect_pc=9'h040 while in WAIT -> next rvalid dropped, id_valid=0, next imem_addr=9'h040.
REQ-030 pc=9'h1FF, fetch completes -> id_pc=9'h1FF and next imem_addr=9'h000.
REQ-031 halt=1 together with redirect=1 -> halted=1, imem_req stays 0 for 10 cycles, pc unchanged; reset clears halted.
REQ-032 IF_PERF_CNT_EN defined, 5 fetches and 2 stall cycles -> perf_fetch=5, perf_stall=2; force perf_fetch to 16'hFFFF, one more fetch -> remains 16'hFFFF.
